// File: rtl/parity_link.sv
// Parity-protected valid/ready link: TX parity generation, a skid-free register pipeline and an
// RX checker with error injection, a sticky error flag and a saturating error counter.
module parity_link #(
  parameter int unsigned DATA_W       = 9,
  parameter int unsigned ODD_PARITY   = 0,
  parameter int unsigned CHECK_STAGES = 1,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  input  logic                 inject_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_parity_ok,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  if (DATA_W < 1 || DATA_W > 32) begin : gen_chk_data_w
    $error("parity_link: DATA_W must be in 1..32");
  end
  if (ODD_PARITY > 1) begin : gen_chk_odd
    $error("parity_link: ODD_PARITY must be 0 or 1");
  end
  if (CHECK_STAGES < 1 || CHECK_STAGES > 4) begin : gen_chk_stages
    $error("parity_link: CHECK_STAGES must be in 1..4");
  end
  if (ERR_CNT_W < 1) begin : gen_chk_cnt_w
    $error("parity_link: ERR_CNT_W must be at least 1");
  end

  localparam logic Odd = (ODD_PARITY != 0);

  // Stage 0 is the TX register; stage CHECK_STAGES feeds the checker.
  logic [CHECK_STAGES:0] valid_q;
  logic [CHECK_STAGES:0] parity_q;
  logic [DATA_W-1:0]     data_q [CHECK_STAGES+1];
  logic [CHECK_STAGES:0] ready;

  logic                  tx_parity;
  logic [DATA_W-1:0]     tx_data;
  logic                  err_event;
  logic                  err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  // A stage may load if it, or any stage downstream of it, is empty, or the consumer is taking
  // the last word this cycle. Accumulated in a local to keep the chain free of self-reference.
  always_comb begin
    logic acc;
    ready = '0;
    acc   = out_ready;
    for (int k = int'(CHECK_STAGES); k >= 0; k--) begin
      acc      = acc | ~valid_q[k];
      ready[k] = acc;
    end
  end

  assign in_ready  = ready[0];
  assign tx_parity = (^in_data) ^ Odd;
  assign tx_data   = in_data ^ DATA_W'(inject_err);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      valid_q  <= '0;
      parity_q <= '0;
      for (int k = 0; k <= int'(CHECK_STAGES); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (ready[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0]   <= tx_data;
          parity_q[0] <= tx_parity;
        end
      end
      for (int k = 1; k <= int'(CHECK_STAGES); k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k]   <= data_q[k-1];
            parity_q[k] <= parity_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid     = valid_q[CHECK_STAGES];
  assign out_data      = data_q[CHECK_STAGES];
  // Gated by out_valid so an empty stage never reports a match or leaks X into the counters.
  assign out_parity_ok = out_valid & (((^out_data) ^ Odd) == parity_q[CHECK_STAGES]);
  assign err_event     = out_valid & out_ready & ~out_parity_ok;

  always_comb begin
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (err_event) begin
      err_flag_d = 1'b1;
      if (err_clr) begin
        err_count_d = ERR_CNT_W'(1);
      end else if (err_count_q != '1) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_parity_link.sv
// Bench for parity_link: three configurations exercised by directed tasks plus a randomized
// scoreboard run against a queue-based reference model.
module tb_parity_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // a: defaults (even parity, 1 check stage, 8-bit counter)
  logic a_rst_n = 1'b0, a_in_valid = 1'b0, a_inject = 1'b0, a_out_ready = 1'b1, a_err_clr = 1'b0;
  logic [8:0] a_in_data = '0, a_out_data;
  logic a_in_ready, a_out_valid, a_ok, a_err_flag;
  logic [7:0] a_err_count;

  // b: odd parity, 3 check stages, 2-bit counter
  logic b_rst_n = 1'b0, b_in_valid = 1'b0, b_inject = 1'b0, b_out_ready = 1'b1, b_err_clr = 1'b0;
  logic [8:0] b_in_data = '0, b_out_data;
  logic b_in_ready, b_out_valid, b_ok, b_err_flag;
  logic [1:0] b_err_count;

  // c: 12-bit data, even parity, 2 check stages, 16-bit counter
  logic c_rst_n = 1'b0, c_in_valid = 1'b0, c_inject = 1'b0, c_out_ready = 1'b1, c_err_clr = 1'b0;
  logic [11:0] c_in_data = '0, c_out_data;
  logic c_in_ready, c_out_valid, c_ok, c_err_flag;
  logic [15:0] c_err_count;

  parity_link #(.DATA_W(9), .ODD_PARITY(0), .CHECK_STAGES(1), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .clear_n(a_rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .inject_err(a_inject), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_parity_ok(a_ok),
    .err_flag(a_err_flag), .err_count(a_err_count), .err_clr(a_err_clr)
  );

  parity_link #(.DATA_W(9), .ODD_PARITY(1), .CHECK_STAGES(3), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .clear_n(b_rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .inject_err(b_inject), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_parity_ok(b_ok),
    .err_flag(b_err_flag), .err_count(b_err_count), .err_clr(b_err_clr)
  );

  parity_link #(.DATA_W(12), .ODD_PARITY(0), .CHECK_STAGES(2), .ERR_CNT_W(16)) dut_c (
    .clk(clk), .clear_n(c_rst_n), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .inject_err(c_inject), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_parity_ok(c_ok),
    .err_flag(c_err_flag), .err_count(c_err_count), .err_clr(c_err_clr)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid got=%b exp=0", a_out_valid); end
    n_checks++; if (a_out_data !== 9'h000) begin n_fail++; $display("FAIL rst_a_data got=%h exp=000", a_out_data); end
    n_checks++; if (a_ok !== 1'b0) begin n_fail++; $display("FAIL rst_a_ok got=%b exp=0", a_ok); end
    n_checks++; if (b_ok !== 1'b0) begin n_fail++; $display("FAIL rst_b_ok got=%b exp=0", b_ok); end
    n_checks++; if (a_err_flag !== 1'b0) begin n_fail++; $display("FAIL rst_a_flag got=%b exp=0", a_err_flag); end
    n_checks++; if (a_err_count !== 8'd0) begin n_fail++; $display("FAIL rst_a_count got=%0d exp=0", a_err_count); end
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_c_valid got=%b exp=0", c_out_valid); end
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_in_ready got=%b exp=1", a_in_ready); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_in_ready got=%b exp=1", b_in_ready); end
    n_checks++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_c_in_ready got=%b exp=1", c_in_ready); end
  endtask

  task automatic test_basic();
    a_out_ready = 1'b1;
    @(negedge clk); a_in_valid = 1'b1; a_in_data = 9'h0FF; a_inject = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=1", a_in_ready); end
    @(negedge clk); a_in_data = 9'h001;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got=%b exp=0", a_out_valid); end
    @(negedge clk); a_in_valid = 1'b0;
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_w0_valid got=%b exp=1", a_out_valid); end
    n_checks++; if (a_out_data !== 9'h0FF) begin n_fail++; $display("FAIL basic_w0_data got=%h exp=0ff", a_out_data); end
    n_checks++; if (a_ok !== 1'b1) begin n_fail++; $display("FAIL basic_w0_ok got=%b exp=1", a_ok); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_w1_valid got=%b exp=1", a_out_valid); end
    n_checks++; if (a_out_data !== 9'h001) begin n_fail++; $display("FAIL basic_w1_data got=%h exp=001", a_out_data); end
    n_checks++; if (a_ok !== 1'b1) begin n_fail++; $display("FAIL basic_w1_ok got=%b exp=1", a_ok); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got=%b exp=0", a_out_valid); end
    n_checks++; if (a_err_count !== 8'd0) begin n_fail++; $display("FAIL basic_count got=%0d exp=0", a_err_count); end
  endtask

  // Sends one word into b, waits for it at the output and consumes it; lat counts cycles
  // from the accepting edge to the first cycle out_valid is seen.
  task automatic b_xfer(input logic [8:0] d, input logic inj, input logic clr,
                        output logic [8:0] od, output logic ook, output int lat, output bit tmo);
    od = '0; ook = 1'b0; tmo = 1'b1; lat = 0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d; b_inject = inj; b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0; b_inject = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (b_out_valid) begin
      od = b_out_data; ook = b_ok; tmo = 1'b0;
      b_err_clr = clr;
    end
    @(negedge clk);
    b_err_clr = 1'b0;
  endtask

  task automatic test_inject();
    logic [8:0] od; logic ook; int lat; bit tmo;
    b_xfer(9'h000, 1'b1, 1'b0, od, ook, lat, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL inj_timeout got=%b exp=0", tmo); end
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL inj_latency got=%0d exp=4", lat); end
    n_checks++; if (od !== 9'h001) begin n_fail++; $display("FAIL inj_data got=%h exp=001", od); end
    n_checks++; if (ook !== 1'b0) begin n_fail++; $display("FAIL inj_ok got=%b exp=0", ook); end
    n_checks++; if (b_err_flag !== 1'b1) begin n_fail++; $display("FAIL inj_flag got=%b exp=1", b_err_flag); end
    n_checks++; if (b_err_count !== 2'd1) begin n_fail++; $display("FAIL inj_count got=%0d exp=1", b_err_count); end
    b_xfer(9'h1A5, 1'b0, 1'b0, od, ook, lat, tmo);
    n_checks++; if (od !== 9'h1A5) begin n_fail++; $display("FAIL odd_clean_data got=%h exp=1a5", od); end
    n_checks++; if (ook !== 1'b1) begin n_fail++; $display("FAIL odd_clean_ok got=%b exp=1", ook); end
    n_checks++; if (b_err_count !== 2'd1) begin n_fail++; $display("FAIL odd_clean_count got=%0d exp=1", b_err_count); end
  endtask

  task automatic test_backpressure();
    int next = 1, accepted = 0, got = 0;
    int exp_q[$];
    int e;
    b_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = 9'(next);
      #1;
      if (b_in_ready) begin exp_q.push_back(next); next++; accepted++; end
    end
    n_checks++; if (accepted != 4) begin n_fail++; $display("FAIL bp_capacity got=%0d exp=4", accepted); end
    n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", b_in_ready); end
    n_checks++; if (b_out_data !== 9'd1) begin n_fail++; $display("FAIL bp_hold_data got=%0d exp=1", b_out_data); end
    for (int cyc = 0; cyc < 80 && got < 12; cyc++) begin
      @(negedge clk);
      if (next <= 12) begin b_in_valid = 1'b1; b_in_data = 9'(next); end
      else b_in_valid = 1'b0;
      b_out_ready = 1'b1;
      #1;
      if (b_in_valid && b_in_ready) begin exp_q.push_back(next); next++; end
      if (b_out_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        got++;
        n_checks++; if (int'(b_out_data) != e || b_ok !== 1'b1) begin n_fail++; $display("FAIL bp_order got=%0d/%b exp=%0d/1", b_out_data, b_ok, e); end
      end
    end
    b_in_valid = 1'b0;
    n_checks++; if (got != 12) begin n_fail++; $display("FAIL bp_count got=%0d exp=12", got); end
  endtask

  task automatic test_err_sat();
    logic [8:0] od; logic ook; int lat; bit tmo;
    int exp_cnt;
    @(negedge clk); b_err_clr = 1'b1;
    @(negedge clk); b_err_clr = 1'b0;
    n_checks++; if (b_err_count !== 2'd0) begin n_fail++; $display("FAIL clr_count got=%0d exp=0", b_err_count); end
    n_checks++; if (b_err_flag !== 1'b0) begin n_fail++; $display("FAIL clr_flag got=%b exp=0", b_err_flag); end
    for (int i = 0; i < 5; i++) begin
      b_xfer(9'($urandom), 1'b1, 1'b0, od, ook, lat, tmo);
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      n_checks++; if (int'(b_err_count) != exp_cnt || tmo) begin n_fail++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, b_err_count, exp_cnt); end
    end
    b_xfer(9'($urandom), 1'b1, 1'b1, od, ook, lat, tmo);
    n_checks++; if (b_err_count !== 2'd1) begin n_fail++; $display("FAIL clr_vs_event_count got=%0d exp=1", b_err_count); end
    n_checks++; if (b_err_flag !== 1'b1) begin n_fail++; $display("FAIL clr_vs_event_flag got=%b exp=1", b_err_flag); end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); a_in_valid = 1'b1; a_in_data = 9'(9'h010 + i);
    end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got=%b exp=1", a_out_valid); end
    #2 a_rst_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", a_out_valid); end
    n_checks++; if (a_out_data !== 9'h000) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=000", a_out_data); end
    n_checks++; if (a_ok !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ok got=%b exp=0", a_ok); end
    @(negedge clk); a_in_valid = 1'b0; a_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d] got=%b exp=0", i, a_out_valid); end
    end
    a_in_valid = 1'b1; a_in_data = 9'h155;
    @(negedge clk); a_in_valid = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat_early got=%b exp=0", a_out_valid); end
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 9'h155) begin n_fail++; $display("FAIL mid_lat2 got=%b/%h exp=1/155", a_out_valid, a_out_data); end
  endtask

  task automatic test_random();
    logic [11:0] exp_d[$];
    logic        exp_ok[$];
    logic [11:0] ed;
    logic        eo;
    int sent = 0, got = 0, inj_n = 0;
    bit stalled = 1'b0;
    for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        n_checks++; if (c_out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_hold got=%b exp=1", c_out_valid); end
      end
      c_in_valid  = (sent < 10000) && ($urandom_range(0, 99) < 70);
      c_in_data   = 12'($urandom);
      c_inject    = ($urandom_range(0, 99) < 5);
      c_out_ready = ($urandom_range(0, 99) < 70);
      #1;
      if (c_in_valid && c_in_ready) begin
        exp_d.push_back(c_inject ? (c_in_data ^ 12'h001) : c_in_data);
        exp_ok.push_back(!c_inject);
        sent++;
        if (c_inject) inj_n++;
      end
      if (c_out_valid && c_out_ready) begin
        got++;
        if (exp_d.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rand_spurious got=%h exp=none", c_out_data);
        end else begin
          ed = exp_d.pop_front(); eo = exp_ok.pop_front();
          n_checks++; if (c_out_data !== ed || c_ok !== eo) begin n_fail++; $display("FAIL rand_word[%0d] got=%h/%b exp=%h/%b", got, c_out_data, c_ok, ed, eo); end
        end
      end
      stalled = c_out_valid && !c_out_ready;
    end
    c_in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (got != 10000) begin n_fail++; $display("FAIL rand_words got=%0d exp=10000", got); end
    n_checks++; if (int'(c_err_count) != inj_n) begin n_fail++; $display("FAIL rand_err_count got=%0d exp=%0d", c_err_count, inj_n); end
    n_checks++; if (c_err_flag !== (inj_n != 0)) begin n_fail++; $display("FAIL rand_err_flag got=%b exp=%b", c_err_flag, inj_n != 0); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_inject();
    test_backpressure();
    test_err_sat();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
